// File: rtl/agcseq16_pkg.sv
// rtl/agcseq16_pkg.sv - shared constants for the AGC configuration sequencer
//
// Purpose: preset configuration words, host-register reset values, sequencer
//          state encoding and host register address codes.
// Ports:   none (package).
package agcseq16_pkg;

   // Preset word0/word1; word2 of every preset is the user U2 shadow.
   localparam logic [15:0] SLOW_W0 = 16'hA420;
   localparam logic [15:0] SLOW_W1 = 16'h8008;
   localparam logic [15:0] MED_W0  = 16'hA520;
   localparam logic [15:0] MED_W1  = 16'h4008;
   localparam logic [15:0] FAST_W0 = 16'hA720;
   localparam logic [15:0] FAST_W1 = 16'h1008;

   // Preset selectors
   localparam logic [1:0] SEL_SLOW = 2'd0;
   localparam logic [1:0] SEL_MED  = 2'd1;
   localparam logic [1:0] SEL_FAST = 2'd2;
   localparam logic [1:0] SEL_USER = 2'd3;

   // Host register reset values
   localparam logic [15:0] U0_RST    = 16'hA520;
   localparam logic [15:0] U1_RST    = 16'h4008;
   localparam logic [15:0] U2_RST    = 16'h00DF;
   localparam logic [1:0]  MODE_RST  = SEL_MED;
   localparam logic [7:0]  RTIME_RST = 8'd16;

   // Sequencer states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_S0   = 2'd1;
   localparam logic [1:0] ST_S1   = 2'd2;
   localparam logic [1:0] ST_S2   = 2'd3;

   // Host register addresses
   localparam logic [1:0] ADDR_U0   = 2'd0;
   localparam logic [1:0] ADDR_U1   = 2'd1;
   localparam logic [1:0] ADDR_U2   = 2'd2;
   localparam logic [1:0] ADDR_CTRL = 2'd3;

endpackage

// File: rtl/agcseq16.sv
// rtl/agcseq16.sv - AGC configuration sequencer with post-transmit recovery
//
// Purpose: holds the host user shadows and control register, and writes a
//          complete three-word parameter set into the AGC whenever a request
//          is pending. After transmit it forces the FAST preset for a timed
//          recovery window of 256*rtime sample strobes.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   din, a, wr      host write data, register address, write strobe
//   dout            host read data (combinational on a)
//   ptt             transmit key
//   iv              sample strobe, paces the recovery counter
//   cin             AGC configuration word
//   w0, w1, w2      AGC configuration write strobes (one-hot pulses)
//   busy            sequence running or pending
module agcseq16
   import agcseq16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] din,
   input  logic [1:0]  a,
   input  logic        wr,
   output logic [15:0] dout,
   input  logic        ptt,
   input  logic        iv,
   output logic [15:0] cin,
   output logic        w0,
   output logic        w1,
   output logic        w2,
   output logic        busy
);

   logic [15:0] r_u0, r_u1, r_u2;
   logic [1:0]  r_mode;
   logic [7:0]  r_rtime;
   logic        r_pend;
   logic        r_rec;
   logic [15:0] r_rctr;
   logic        r_ptt_q;
   logic [1:0]  r_state;
   logic [1:0]  r_sel;
   logic [15:0] r_cin;
   logic        r_w0, r_w1, r_w2;

   logic        w_ptt_fall, w_ptt_rise;
   logic        w_rec_start, w_rec_abort, w_rec_done;
   logic        w_host_req, w_req, w_start_seq;
   logic [1:0]  w_sel_now;

   function automatic logic [15:0] preset_word(input logic [1:0]  sel,
                                               input logic [1:0]  idx,
                                               input logic [15:0] u0,
                                               input logic [15:0] u1,
                                               input logic [15:0] u2);
      logic [15:0] word;
      word = u2;
      if (idx == 2'd0) begin
         case (sel)
            SEL_SLOW: word = SLOW_W0;
            SEL_MED:  word = MED_W0;
            SEL_FAST: word = FAST_W0;
            default:  word = u0;
         endcase
      end else if (idx == 2'd1) begin
         case (sel)
            SEL_SLOW: word = SLOW_W1;
            SEL_MED:  word = MED_W1;
            SEL_FAST: word = FAST_W1;
            default:  word = u1;
         endcase
      end
      return word;
   endfunction

   assign w_ptt_fall  = r_ptt_q & ~ptt;
   assign w_ptt_rise  = ~r_ptt_q & ptt;
   assign w_rec_start = w_ptt_fall & (r_rtime != 8'd0);
   assign w_rec_abort = w_ptt_rise & r_rec;
   assign w_rec_done  = r_rec & iv & (r_rctr == 16'd1);

   // U0/U1 only matter to the AGC when the USER preset is selected.
   assign w_host_req = wr & ((a == ADDR_CTRL) || (a == ADDR_U2) ||
                             (((a == ADDR_U0) || (a == ADDR_U1)) && (r_mode == SEL_USER)));
   assign w_req       = w_host_req | w_rec_start | w_rec_abort | w_rec_done;
   assign w_start_seq = (r_state == ST_IDLE) & r_pend;
   assign w_sel_now   = r_rec ? SEL_FAST : r_mode;

   // Host registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_u0    <= U0_RST;
         r_u1    <= U1_RST;
         r_u2    <= U2_RST;
         r_mode  <= MODE_RST;
         r_rtime <= RTIME_RST;
      end else if (wr) begin
         case (a)
            ADDR_U0: r_u0 <= din;
            ADDR_U1: r_u1 <= din;
            ADDR_U2: r_u2 <= din;
            default: begin
               r_mode  <= din[1:0];
               r_rtime <= din[15:8];
            end
         endcase
      end
   end

   // Recovery timer; rtime is only sampled at the ptt falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptt_q <= 1'b0;
         r_rec   <= 1'b0;
         r_rctr  <= 16'd0;
      end else begin
         r_ptt_q <= ptt;
         if (w_rec_start) begin
            r_rec  <= 1'b1;
            r_rctr <= {r_rtime, 8'h00};
         end else if (w_rec_abort) begin
            r_rec  <= 1'b0;
            r_rctr <= 16'd0;
         end else if (r_rec && iv && (r_rctr != 16'd0)) begin
            r_rctr <= r_rctr - 16'd1;
            if (w_rec_done) r_rec <= 1'b0;
         end
      end
   end

   // A new request wins over the clear so nothing is lost at sequence start.
   always_ff @(posedge clk) begin
      if (rst)              r_pend <= 1'b1;
      else if (w_req)       r_pend <= 1'b1;
      else if (w_start_seq) r_pend <= 1'b0;
   end

   // Sequencer; r_sel is frozen at start so presets never mix.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_sel   <= SEL_SLOW;
         r_cin   <= 16'd0;
         r_w0    <= 1'b0;
         r_w1    <= 1'b0;
         r_w2    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_w2 <= 1'b0;
               if (r_pend) begin
                  r_state <= ST_S0;
                  r_sel   <= w_sel_now;
                  r_cin   <= preset_word(w_sel_now, 2'd0, r_u0, r_u1, r_u2);
                  r_w0    <= 1'b1;
               end
            end
            ST_S0: begin
               r_state <= ST_S1;
               r_cin   <= preset_word(r_sel, 2'd1, r_u0, r_u1, r_u2);
               r_w0    <= 1'b0;
               r_w1    <= 1'b1;
            end
            ST_S1: begin
               r_state <= ST_S2;
               r_cin   <= preset_word(r_sel, 2'd2, r_u0, r_u1, r_u2);
               r_w1    <= 1'b0;
               r_w2    <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_w2    <= 1'b0;
            end
         endcase
      end
   end

   assign cin  = r_cin;
   assign w0   = r_w0;
   assign w1   = r_w1;
   assign w2   = r_w2;
   assign busy = (r_state != ST_IDLE) | r_pend;

   always_comb begin
      dout = 16'd0;
      case (a)
         ADDR_U0: dout = r_u0;
         ADDR_U1: dout = r_u1;
         ADDR_U2: dout = r_u2;
         default: dout = {r_rtime, 4'b0000, busy, r_rec, r_mode};
      endcase
   end

endmodule

// File: tb/tb_agcseq16.sv
// tb/tb_agcseq16.sv - self-checking bench for agcseq16
//
// Purpose: drives directed host writes, ptt and iv, compares every output
//          against a queue-based behavioural model each cycle, and pins the
//          model with hand-computed preset sequences.
// Ports:   none (top-level bench).
module tb_agcseq16;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] din;
   logic [1:0]  a;
   logic        wr;
   logic [15:0] dout;
   logic        ptt;
   logic        iv;
   logic [15:0] cin;
   logic        w0, w1, w2;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   agcseq16 dut (
      .clk  (clk),
      .rst  (rst),
      .din  (din),
      .a    (a),
      .wr   (wr),
      .dout (dout),
      .ptt  (ptt),
      .iv   (iv),
      .cin  (cin),
      .w0   (w0),
      .w1   (w1),
      .w2   (w2),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each started sequence queues its remaining slots (sel*4+idx); idx 3 is
   // the mandatory idle slot after the third word.
   logic [15:0] m_u0, m_u1, m_u2;
   int          m_mode, m_rtime;
   bit          m_rec, m_req, m_pptt;
   int          m_rem;
   int          m_q[$];
   logic [15:0] e_cin;
   logic [2:0]  e_w;
   bit          started = 0;

   function automatic logic [15:0] mword(input int sel, input int idx);
      logic [15:0] t0[4];
      logic [15:0] t1[4];
      t0 = '{16'hA420, 16'hA520, 16'hA720, m_u0};
      t1 = '{16'h8008, 16'h4008, 16'h1008, m_u1};
      if (idx == 0) return t0[sel];
      if (idx == 1) return t1[sel];
      return m_u2;
   endfunction

   function automatic bit m_busy();
      return (m_q.size() > 0) || m_req;
   endfunction

   function automatic logic [15:0] m_dout(input logic [1:0] addr);
      case (addr)
         2'd0: return m_u0;
         2'd1: return m_u1;
         2'd2: return m_u2;
         default: return {m_rtime[7:0], 4'b0000, m_busy(), m_rec, m_mode[1:0]};
      endcase
   endfunction

   always @(posedge clk) begin
      bit new_req, cleared;
      int ent, s;
      started = 1;
      if (rst) begin
         m_u0 = 16'hA520; m_u1 = 16'h4008; m_u2 = 16'h00DF;
         m_mode = 1; m_rtime = 16;
         m_rec = 0; m_rem = 0; m_pptt = 0; m_req = 1;
         m_q.delete();
         e_cin = 16'd0; e_w = 3'b000;
      end else begin
         new_req = 0; cleared = 0;
         e_w = 3'b000;
         if (m_q.size() > 0) begin
            ent = m_q.pop_front();
            if ((ent % 4) != 3) begin
               e_cin = mword(ent / 4, ent % 4);
               e_w[ent % 4] = 1'b1;
            end
         end else if (m_req) begin
            s = m_rec ? 2 : m_mode;
            e_cin = mword(s, 0);
            e_w = 3'b001;
            m_q.push_back(s * 4 + 1);
            m_q.push_back(s * 4 + 2);
            m_q.push_back(s * 4 + 3);
            cleared = 1;
         end
         // recovery uses the pre-write rtime
         if (m_pptt && !ptt) begin
            if (m_rtime != 0) begin
               m_rec = 1; m_rem = m_rtime * 256; new_req = 1;
            end
         end else if (!m_pptt && ptt && m_rec) begin
            m_rec = 0; m_rem = 0; new_req = 1;
         end else if (m_rec && iv && m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin m_rec = 0; new_req = 1; end
         end
         m_pptt = ptt;
         if (wr) begin
            case (a)
               2'd0: begin if (m_mode == 3) new_req = 1; m_u0 = din; end
               2'd1: begin if (m_mode == 3) new_req = 1; m_u1 = din; end
               2'd2: begin m_u2 = din; new_req = 1; end
               default: begin m_mode = din[1:0]; m_rtime = din[15:8]; new_req = 1; end
            endcase
         end
         if (new_req) m_req = 1;
         else if (cleared) m_req = 0;
      end
   end

   // ---------------- per-cycle compare and strobe log ----------------
   logic [17:0] ev_q[$];

   always @(posedge clk) begin
      #3;
      if (started) begin
         chk("cin", cin, e_cin);
         chk("w0", w0, e_w[0]);
         chk("w1", w1, e_w[1]);
         chk("w2", w2, e_w[2]);
         chk("busy", busy, m_busy());
         chk("dout", dout, m_dout(a));
         chk("strobe_excl", ($countones({w2, w1, w0}) <= 1), 1);
         if (w0) ev_q.push_back({2'd0, cin});
         else if (w1) ev_q.push_back({2'd1, cin});
         else if (w2) ev_q.push_back({2'd2, cin});
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic host_wr(input logic [1:0] addr, input logic [15:0] data);
      a = addr; din = data; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic pulse_iv(input int n);
      repeat (n) begin
         iv = 1'b1; @(negedge clk);
         iv = 1'b0; @(negedge clk);
      end
   endtask

   task automatic chk_seq(input string nm, input logic [15:0] c0,
                          input logic [15:0] c1, input logic [15:0] c2);
      chk({nm, "_count"}, ev_q.size(), 3);
      if (ev_q.size() == 3) begin
         chk({nm, "_w0"}, ev_q[0], {2'd0, c0});
         chk({nm, "_w1"}, ev_q[1], {2'd1, c1});
         chk({nm, "_w2"}, ev_q[2], {2'd2, c2});
      end
      ev_q.delete();
   endtask

   initial begin
      rst = 1'b1; din = 16'd0; a = 2'd3; wr = 1'b0; ptt = 1'b0; iv = 1'b0;
      cyc(3);
      chk("reset_busy", busy, 1);
      chk("reset_cin", cin, 16'h0000);
      chk("reset_strobes", {w2, w1, w0}, 3'b000);
      rst = 1'b0;
      cyc(8);
      chk_seq("post_reset", 16'hA520, 16'h4008, 16'h00DF);
      chk("idle_busy", busy, 0);

      // FAST mode, rtime 0x10
      host_wr(2'd3, 16'h1002);
      cyc(8);
      chk_seq("fast_mode", 16'hA720, 16'h1008, 16'h00DF);
      chk("ctrl_rtime", dout[15:8], 8'h10);
      chk("ctrl_mode", dout[1:0], 2'd2);

      // USER mode, then adjacent U0/U1 writes
      host_wr(2'd3, 16'h1003);
      cyc(8);
      chk_seq("user_mode", 16'hA520, 16'h4008, 16'h00DF);
      a = 2'd0; din = 16'h5310; wr = 1'b1;
      @(negedge clk);
      a = 2'd1; din = 16'h2010;
      @(negedge clk);
      wr = 1'b0; a = 2'd3;
      cyc(12);
      chk("user_ev_count", ev_q.size(), 6);
      if (ev_q.size() == 6) begin
         chk("user_first_w0", ev_q[0], {2'd0, 16'h5310});
         chk("user_second_w0", ev_q[3], {2'd0, 16'h5310});
         chk("user_second_w1", ev_q[4], {2'd1, 16'h2010});
         chk("user_second_w2", ev_q[5], {2'd2, 16'h00DF});
      end
      ev_q.delete();

      // rtime=1, SLOW mode, then recovery
      host_wr(2'd3, 16'h0100);
      cyc(8);
      chk_seq("slow_mode", 16'hA420, 16'h8008, 16'h00DF);
      ptt = 1'b1;
      cyc(4);
      chk("ptt_rise_no_seq", ev_q.size(), 0);
      ptt = 1'b0;
      cyc(8);
      chk_seq("rec_fast", 16'hA720, 16'h1008, 16'h00DF);
      chk("rec_set", dout[2], 1);
      pulse_iv(255);
      chk("rec_at_255", dout[2], 1);
      pulse_iv(1);
      chk("rec_expired", dout[2], 0);
      cyc(8);
      chk_seq("rec_restore", 16'hA420, 16'h8008, 16'h00DF);

      // abort after 10 iv, then restart with full count
      ptt = 1'b1; cyc(3);
      ptt = 1'b0; cyc(8);
      chk_seq("rec2_fast", 16'hA720, 16'h1008, 16'h00DF);
      pulse_iv(10);
      ptt = 1'b1;
      cyc(2);
      chk("abort_rec", dout[2], 0);
      cyc(6);
      chk_seq("abort_restore", 16'hA420, 16'h8008, 16'h00DF);
      ptt = 1'b0;
      cyc(8);
      chk_seq("rec3_fast", 16'hA720, 16'h1008, 16'h00DF);
      pulse_iv(255);
      chk("rec3_at_255", dout[2], 1);
      pulse_iv(1);
      chk("rec3_expired", dout[2], 0);
      cyc(8);
      chk_seq("rec3_restore", 16'hA420, 16'h8008, 16'h00DF);

      // reset while the sequence is in S0
      host_wr(2'd3, 16'h1001);
      @(negedge clk);
      chk("pre_rst_w0", w0, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_strobes", {w2, w1, w0}, 3'b000);
      rst = 1'b0;
      cyc(6);
      chk("rst_ev_count", ev_q.size(), 4);
      if (ev_q.size() == 4) begin
         chk("rst_partial_w0", ev_q[0], {2'd0, 16'hA520});
         chk("rst_full_w0", ev_q[1], {2'd0, 16'hA520});
         chk("rst_full_w1", ev_q[2], {2'd1, 16'h4008});
         chk("rst_full_w2", ev_q[3], {2'd2, 16'h00DF});
      end
      ev_q.delete();
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
